channel_sequencer: RTL

- Downstream consumer of the interval counter.
- Uses that counter's end-of-interval warning window (switch_i_c) to rotate one active output channel among NUM_CH channels.
- Drives a pre-switch warning flag and enforces an all-off dead time between channels.
- Supports a manual skip request with a req/ack handshake.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/channel_sequencer_if.sv | 28 ++
 rtl/edge_detect.sv | 22 ++
 rtl/channel_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the channel sequencer slice.
// State encodings, parameter defaults and a counter width helper.
package seq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACTIVE = 2'd1;
   localparam state_t ST_WARN   = 2'd2;
   localparam state_t ST_DEAD   = 2'd3;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_DEAD_TICKS = 2;

   // Bits needed to hold the value n without wrapping.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/channel_sequencer_if.sv
// Control and status bundle of the channel sequencer.
// master drives run control and requests; slave is the sequencer.
interface channel_sequencer_if import seq_pkg::*; #(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = $clog2(NUM_CH)
);

   logic              enable;
   logic              tick;
   logic              switch_i_c;
   logic              skip_req;
   logic              skip_ack;
   logic [NUM_CH-1:0] ch_on;
   logic              warn;
   logic [CH_W-1:0]   active_idx;
   logic              cycle_done;

   modport master (
      output enable, tick, switch_i_c, skip_req,
      input  skip_ack, ch_on, warn, active_idx, cycle_done
   );

   modport slave (
      input  enable, tick, switch_i_c, skip_req,
      output skip_ack, ch_on, warn, active_idx, cycle_done
   );

endinterface

// File: rtl/edge_detect.sv
// One-flop edge detector for a synchronous level input.
// rise/fall are combinational against the previous sample.
module edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic q;

   // Remember last clock's level of the input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) q <= 1'b0;
      else       q <= din;
   end

   assign rise = din & ~q;
   assign fall = ~din & q;

endmodule

// File: rtl/channel_sequencer.sv
// Rotates one active channel on the counter's warning window,
// with an all-off dead time and a req/ack skip request.
module channel_sequencer import seq_pkg::*; #(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DEAD_TICKS = DEF_DEAD_TICKS,
   parameter int CH_W       = $clog2(NUM_CH)
) (
   input  logic               clock,
   input  logic               reset,
   channel_sequencer_if.slave bus
);

   localparam int              DW      = cnt_width(DEAD_TICKS);
   localparam bit              NO_DEAD = (DEAD_TICKS == 0);
   localparam logic [DW-1:0]   LAST    =
      DW'(DEAD_TICKS > 0 ? DEAD_TICKS - 1 : 0);
   localparam logic [CH_W-1:0] IDX_MAX = CH_W'(NUM_CH - 1);

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] ch_on_q, ch_on_d;
   logic              warn_q, warn_d;
   logic [CH_W-1:0]   idx_q, idx_d, idx_nxt;
   logic              ack_q, ack_d;
   logic              cd_q, cd_d;
   logic [DW-1:0]     dead_q, dead_d;
   logic              armed_q, armed_d;

   logic rise, fall;
   logic in_run, accept, dead_exit, enter_dead;

   edge_detect u_sw_edge (
      .clock (clock),
      .reset (reset),
      .din   (bus.switch_i_c),
      .rise  (rise),
      .fall  (fall)
   );

   assign in_run    = (state_q == ST_ACTIVE) || (state_q == ST_WARN);
   assign accept    = bus.enable & bus.skip_req & armed_q & in_run;
   assign dead_exit = (state_q == ST_DEAD) &&
                      (NO_DEAD || (bus.tick && dead_q == LAST));
   assign idx_nxt   = (idx_q == IDX_MAX) ? '0 : idx_q + CH_W'(1);
   assign enter_dead = bus.enable && (state_q != ST_DEAD) &&
                       (state_d == ST_DEAD);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: enable dominates, skip beats window edges.
   always_comb begin
      state_d = state_q;
      if (!bus.enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:   state_d = ST_ACTIVE;
            ST_ACTIVE: begin
               if (accept)    state_d = ST_DEAD;
               else if (rise) state_d = ST_WARN;
               else if (fall) state_d = ST_DEAD;
            end
            ST_WARN: begin
               if (accept || fall) state_d = ST_DEAD;
            end
            ST_DEAD: begin
               if (dead_exit) state_d = ST_ACTIVE;
            end
         endcase
      end
   end

   // Next values of the registered outputs and counters.
   always_comb begin
      ch_on_d = ch_on_q;
      warn_d  = warn_q;
      idx_d   = idx_q;
      dead_d  = dead_q;
      cd_d    = 1'b0;
      ack_d   = accept;
      armed_d = bus.skip_req ? (armed_q & ~accept) : 1'b1;
      if (!bus.enable) begin
         ch_on_d = '0;
         warn_d  = 1'b0;
      end else if (enter_dead) begin
         ch_on_d = '0;
         warn_d  = 1'b0;
         dead_d  = '0;
      end else if (state_q == ST_IDLE) begin
         ch_on_d = NUM_CH'(1) << idx_q;
         warn_d  = 1'b0;
      end else if (state_q == ST_ACTIVE && rise) begin
         warn_d = 1'b1;
      end else if (dead_exit) begin
         idx_d   = idx_nxt;
         ch_on_d = NUM_CH'(1) << idx_nxt;
         cd_d    = (idx_q == IDX_MAX);
      end else if (state_q == ST_DEAD && bus.tick) begin
         dead_d = dead_q + DW'(1);
      end
   end

   // Output and counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ch_on_q <= '0;
         warn_q  <= 1'b0;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         cd_q    <= 1'b0;
         dead_q  <= '0;
         armed_q <= 1'b1;
      end else begin
         ch_on_q <= ch_on_d;
         warn_q  <= warn_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         cd_q    <= cd_d;
         dead_q  <= dead_d;
         armed_q <= armed_d;
      end
   end

   assign bus.ch_on      = ch_on_q;
   assign bus.warn       = warn_q;
   assign bus.active_idx = idx_q;
   assign bus.skip_ack   = ack_q;
   assign bus.cycle_done = cd_q;

endmodule
